// File: rtl/stepdown_gate_pkg.sv
// Shared definitions for the stepdown break-before-make gate controller.
//   - state_e : FSM state encoding, also exported on the STATE debug port
//   - PGATE_OFF / NGATE_OFF : gate levels that turn each power FET off
//   - default widths for dead-time, min-on and fault-count fields
package stepdown_gate_pkg;

  localparam int DT_W_DEF    = 4;
  localparam int MINON_W_DEF = 4;
  localparam int FCNT_W_DEF  = 8;

  localparam logic PGATE_OFF = 1'b1;
  localparam logic NGATE_OFF = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DT_HS  = 3'd1,
    ST_HS_ON  = 3'd2,
    ST_DT_LS  = 3'd3,
    ST_LS_ON  = 3'd4,
    ST_ZC_OFF = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

endpackage

// File: rtl/stepdown_gate_dtcnt.sv
// Loadable down-counter with a minimum-of-1 clamp.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : force count to 0 (highest priority)
//   load_i      : load max(load_val_i, 1)
//   load_val_i  : value to load
//   expire_o    : count has reached 1
// The count stops at 1, so expire_o stays high until the next load or clear.
module stepdown_gate_dtcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (load_val_i == '0) ? ONE : load_val_i;
    end else if (cnt_q > ONE) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == ONE);

endmodule

// File: rtl/stepdown_gate_ctrl.sv
// Break-before-make gate controller for the stepdown power stage.
//   CLK, RESETN          : clock, async active-low reset
//   ENABLE, PWM_IN       : stage enable, high-side request
//   DT_HS_CFG, DT_LS_CFG : dead time before HS / LS turn-on (cycles, 0 acts as 1)
//   MINON_CFG            : minimum high-side on-time (cycles)
//   FAULT_IN, FAULT_CLR  : over-current comparator, fault clear pulse
//   ZCD_IN               : low-side zero-cross detect
//   PGATE (active-low), NGATE (active-high) : power FET gates
//   FAULT_FLAG, FAULT_CNT, STATE : status / debug
// Gate outputs are registered from the next state so they move with STATE.
module stepdown_gate_ctrl
  import stepdown_gate_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int MINON_W = MINON_W_DEF,
  parameter int FCNT_W  = FCNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               ENABLE,
  input  logic               PWM_IN,
  input  logic [DT_W-1:0]    DT_HS_CFG,
  input  logic [DT_W-1:0]    DT_LS_CFG,
  input  logic [MINON_W-1:0] MINON_CFG,
  input  logic               FAULT_IN,
  input  logic               FAULT_CLR,
  input  logic               ZCD_IN,
  output logic               PGATE,
  output logic               NGATE,
  output logic               FAULT_FLAG,
  output logic [FCNT_W-1:0]  FAULT_CNT,
  output logic [2:0]         STATE
);

  state_e            state_q, state_d;
  logic              pgate_q, ngate_q, fault_flag_q;
  logic [FCNT_W-1:0] fcnt_q;

  logic              dt_load, mo_load, cnt_clr;
  logic [DT_W-1:0]   dt_val;
  logic              dt_exp, mo_exp;

  always_comb begin
    state_d = state_q;
    // fault entry outranks ENABLE=0, and FAULT ignores ENABLE entirely
    if (FAULT_IN && (state_q == ST_DT_HS || state_q == ST_HS_ON)) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (FAULT_CLR && !FAULT_IN) state_d = ST_IDLE;
    end else if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = PWM_IN ? ST_DT_HS : ST_DT_LS;
        ST_DT_HS:  if (dt_exp) state_d = ST_HS_ON;
        ST_HS_ON:  if (!PWM_IN && mo_exp) state_d = ST_DT_LS;
        ST_DT_LS:  if (dt_exp) state_d = ST_LS_ON;
        ST_LS_ON:  if (PWM_IN) state_d = ST_DT_HS;
                   else if (ZCD_IN) state_d = ST_ZC_OFF;
        ST_ZC_OFF: if (PWM_IN) state_d = ST_DT_HS;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // counters load on the edge that enters their state
  always_comb begin
    dt_load = ((state_d == ST_DT_HS) && (state_q != ST_DT_HS)) ||
              ((state_d == ST_DT_LS) && (state_q != ST_DT_LS));
    dt_val  = (state_d == ST_DT_HS) ? DT_HS_CFG : DT_LS_CFG;
    mo_load = (state_d == ST_HS_ON) && (state_q != ST_HS_ON);
    cnt_clr = (state_d == ST_IDLE);
  end

  stepdown_gate_dtcnt #(.W(DT_W)) u_dt_cnt (
    .clk        (CLK),
    .rst_n      (RESETN),
    .clr_i      (cnt_clr),
    .load_i     (dt_load),
    .load_val_i (dt_val),
    .expire_o   (dt_exp)
  );

  stepdown_gate_dtcnt #(.W(MINON_W)) u_mo_cnt (
    .clk        (CLK),
    .rst_n      (RESETN),
    .clr_i      (cnt_clr),
    .load_i     (mo_load),
    .load_val_i (MINON_CFG),
    .expire_o   (mo_exp)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      pgate_q      <= PGATE_OFF;
      ngate_q      <= NGATE_OFF;
      fault_flag_q <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pgate_q      <= (state_d == ST_HS_ON) ? ~PGATE_OFF : PGATE_OFF;
      ngate_q      <= (state_d == ST_LS_ON) ? ~NGATE_OFF : NGATE_OFF;
      fault_flag_q <= (state_d == ST_FAULT);
      if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fcnt_q != '1))
        fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign PGATE      = pgate_q;
  assign NGATE      = ngate_q;
  assign FAULT_FLAG = fault_flag_q;
  assign FAULT_CNT  = fcnt_q;
  assign STATE      = state_q;

endmodule

// File: doc/stepdown_gate_ctrl.md
Name: stepdown_gate_ctrl

Overview:
- Digital break-before-make controller for the stepdown power stage.
- Drives the gate of the 4-ohm high-side power PMOS (PGATE, active-low) and the gate of the low-side power NMOS (NGATE, active-high) from a PWM command.
- Enforces programmable dead time, minimum high-side on-time, over-current fault latch and zero-cross (diode emulation) low-side turn-off.
- Sits between the loop PWM generator and the FET driver buffers in the stepdown driver.

Parameters:
DT_W, 4, width of dead-time config inputs (cycles)
MINON_W, 4, width of minimum high-side on-time config
FCNT_W, 8, width of saturating fault counter

Ports:
CLK  input  1  sole clock
RESETN  input  1  asynchronous active-low reset
ENABLE  input  1  1 = power stage allowed to switch
PWM_IN  input  1  1 = request high side on; synchronous to CLK
DT_HS_CFG  input  DT_W  dead time before high-side turn-on, cycles
DT_LS_CFG  input  DT_W  dead time before low-side turn-on, cycles
MINON_CFG  input  MINON_W  minimum HS_ON cycles
FAULT_IN  input  1  high-side over-current comparator, synchronous
FAULT_CLR  input  1  single-cycle pulse clears latched fault
ZCD_IN  input  1  low-side zero-cross detect, synchronous
PGATE  output  1  PMOS gate, 0 = high side on
NGATE  output  1  NMOS gate, 1 = low side on
FAULT_FLAG  output  1  latched fault
FAULT_CNT  output  FCNT_W  saturating count of fault entries
STATE  output  3  encoded current state, for debug/DFT observation

Behaviour:
- Reset: state IDLE, PGATE=1, NGATE=0, FAULT_FLAG=0, FAULT_CNT=0, all counters 0.
- Outputs are registered, decoded from next state, so they change on the same edge as STATE.
- Gate decode per state:
  - HS_ON: PGATE=0, NGATE=0.
  - LS_ON: PGATE=1, NGATE=1.
  - All other states: PGATE=1, NGATE=0.
- Invariant, every cycle: never PGATE=0 and NGATE=1.
- Invariant, every cycle: any switch between HS_ON and LS_ON passes through at least 1 dead-time cycle.
- States and encoding: IDLE=0, DT_HS=1, HS_ON=2, DT_LS=3, LS_ON=4, ZC_OFF=5, FAULT=6.
- IDLE:
  - ENABLE=1 and PWM_IN=1 -> DT_HS.
  - ENABLE=1 and PWM_IN=0 -> DT_LS.
- DT_HS:
  - Dead-time counter loads max(DT_HS_CFG,1) on entry and decrements each cycle.
  - Exit when counter reaches 1 -> HS_ON, so dead time = max(cfg,1) cycles.
  - A cfg of 0 behaves as 1.
- DT_LS: same counting rule using DT_LS_CFG; exit -> LS_ON.
- Dead time always runs to completion; PWM_IN changes during dead time are ignored until the following state.
- HS_ON:
  - On-time counter loads MINON_CFG on entry.
  - Exit -> DT_LS only when PWM_IN=0 and the counter has expired.
  - MINON_CFG=0: exit is allowed on the first HS_ON cycle in which PWM_IN=0.
- LS_ON:
  - PWM_IN=1 -> DT_HS.
  - ZCD_IN=1 with PWM_IN=0 -> ZC_OFF.
  - If PWM_IN=1 and ZCD_IN=1 together, PWM wins -> DT_HS.
- ZC_OFF: PWM_IN=1 -> DT_HS; otherwise stay.
- Fault entry:
  - FAULT_IN=1 while in DT_HS or HS_ON -> FAULT on the next edge.
  - On entry: FAULT_FLAG=1, FAULT_CNT increments, saturating at all-ones.
- FAULT:
  - Both gates off.
  - Exit -> IDLE only when FAULT_CLR=1 and FAULT_IN=0 in the same cycle; FAULT_FLAG clears on that edge.
  - FAULT_CLR while FAULT_IN=1 is ignored.
  - FAULT_CLR outside FAULT has no effect.
- ENABLE=0:
  - From any state other than FAULT -> IDLE next edge; counters are cleared.
  - FAULT persists through ENABLE=0.
- Priority in any cycle: FAULT entry > ENABLE=0 > normal transitions.

Decomposition:
- Shared package stepdown_gate_pkg holds:
  - state enum and its 3-bit encoding;
  - gate-off constants PGATE_OFF=1 and NGATE_OFF=0;
  - default DT/MINON widths.
- One sub-module, stepdown_gate_dtcnt: a loadable down-counter with min-1 clamp and expire flag.
  - One instance serves the dead-time counter.
  - A second instance serves the min-on counter.

Test Plan:
- Reset, then ENABLE=1, PWM_IN=0, DT_LS_CFG=3 -> STATE IDLE->DT_LS; NGATE rises exactly 3 cycles after DT_LS entry; PGATE stays 1.
- PWM_IN 0->1 in LS_ON, DT_HS_CFG=0 -> NGATE falls, then 1 cycle with both off, then PGATE=0.
- MINON_CFG=5, PWM_IN high for only 1 cycle -> PGATE held 0 for 5 cycles, then DT_LS.
- FAULT_IN=1 in HS_ON -> next edge PGATE=1, FAULT_FLAG=1, FAULT_CNT=1.
  - FAULT_CLR with FAULT_IN=1 -> no exit.
  - FAULT_CLR with FAULT_IN=0 -> IDLE.
  - 300 faults -> FAULT_CNT=255.
- LS_ON with ZCD_IN=1, PWM_IN=0 -> NGATE=0, STATE=5; then PWM_IN=1 -> DT_HS.
  - Repeat with PWM_IN=1 and ZCD_IN=1 together -> DT_HS directly.
- Async RESETN low mid-HS_ON (off clock edge) -> PGATE=1, NGATE=0 immediately.
  - Randomized PWM/ENABLE for 10k cycles -> overlap assertion never fires.
